controller_poller: RTL and testbench

CONTROLLER_POLLER -- requirements
Module: controller_poller

---
 rtl/controller_poller.sv | 191 +++++++++++++++++++
 tb/tb_controller_poller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/controller_poller.sv
// controller_poller: polls NUM_CONTROLLERS serial game-controller shift
// registers in parallel. One poll pulses the latch line, clocks out
// NUM_BUTTONS bits per channel, then updates buttons_out in a single cycle.
// The serial lines are active-low. They are stored active-high, and the first
// bit received ends up in the MSB of its channel field.
// Optional feature: define CONTROLLER_POLLER_EDGE_EN to build the
// pressed_edge register (new presses since the previous poll). Without the
// macro, pressed_edge is tied to zero.
module controller_poller #(
  parameter int NUM_CONTROLLERS = 2,
  parameter int NUM_BUTTONS     = 8,
  parameter int HALF_PERIOD     = 1
) (
  input  logic                                   clk_1,
  input  logic                                   rst_n,
  input  logic                                   poll_req,
  input  logic [NUM_CONTROLLERS-1:0]             controller_data_in_B,
  output logic                                   controller_latch,
  output logic                                   controller_clk_out,
  output logic [NUM_CONTROLLERS*NUM_BUTTONS-1:0] buttons_out,
  output logic [NUM_CONTROLLERS*NUM_BUTTONS-1:0] pressed_edge,
  output logic                                   busy,
  output logic                                   done
);

  // Counter widths leave one spare bit, so the counters never wrap inside a poll.
  localparam int BW = $clog2(NUM_BUTTONS) + 1;
  localparam int PW = $clog2(2 * HALF_PERIOD) + 1;

  localparam logic [PW-1:0] PH_ONE     = PW'(1);
  localparam logic [PW-1:0] LATCH_LAST = PW'(2 * HALF_PERIOD - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_PERIOD - 1);
  localparam logic [BW-1:0] BIT_ONE    = BW'(1);
  localparam logic [BW-1:0] BIT_ALL    = BW'(NUM_BUTTONS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    CLK_HI = 3'd2,
    CLK_LO = 3'd3,
    COMMIT = 3'd4
  } state_t;

  // Channel c lives in element [c]. The packed layout matches the flat
  // output bus, which puts channel c at [c*NUM_BUTTONS +: NUM_BUTTONS].
  typedef logic [NUM_CONTROLLERS-1:0][NUM_BUTTONS-1:0] chan_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          held_q, held_d;
  chan_t         shift_q, shift_d;
  chan_t         shifted;
  chan_t         buttons_q, buttons_d;
  logic          latch_q, clk_q, busy_q, done_q;

  // Each channel shifts left and takes the inverted line in at the LSB.
  // After NUM_BUTTONS samples, the first bit has moved up to the MSB.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CONTROLLERS; gi++) begin : g_shift
      assign shifted[gi] = {shift_q[gi][NUM_BUTTONS-2:0], ~controller_data_in_B[gi]};
    end
  endgenerate

  // Next-state logic: sequence the states, time each phase, and sample on the last cycle of LATCH and CLK_HI.
  // held tracks whether poll_req has been high on every cycle since acceptance.
  // Only such a continuously held request chains straight from COMMIT into the next poll.
  // A fresh pulse that arrives during a poll, including during COMMIT, is dropped.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    held_d    = held_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    unique case (state_q)
      IDLE: begin
        phase_d = '0;
        bit_d   = '0;
        if (poll_req) begin
          state_d = LATCH;
          held_d  = 1'b1;
        end
      end
      LATCH: begin
        held_d = held_q & poll_req;
        if (phase_q == LATCH_LAST) begin
          shift_d = shifted;
          bit_d   = bit_q + BIT_ONE;
          phase_d = '0;
          state_d = CLK_HI;
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end
      CLK_HI: begin
        held_d = held_q & poll_req;
        if (phase_q == HALF_LAST) begin
          shift_d = shifted;
          bit_d   = bit_q + BIT_ONE;
          phase_d = '0;
          state_d = CLK_LO;
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end
      CLK_LO: begin
        held_d = held_q & poll_req;
        if (phase_q == HALF_LAST) begin
          phase_d = '0;
          if (bit_q < BIT_ALL) begin
            state_d = CLK_HI;
          end else begin
            // buttons_out is loaded on the edge into COMMIT, so the new value
            // and done appear in the same cycle.
            state_d   = COMMIT;
            buttons_d = shift_q;
          end
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end
      COMMIT: begin
        phase_d = '0;
        bit_d   = '0;
        if (held_q && poll_req) begin
          state_d = LATCH;
          held_d  = 1'b1;
        end else begin
          state_d = IDLE;
          held_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and data registers. The external strobes are decoded from state_d, so they are registered.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      held_q    <= 1'b0;
      shift_q   <= '0;
      buttons_q <= '0;
      latch_q   <= 1'b0;
      clk_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      held_q    <= held_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      latch_q   <= (state_d == LATCH);
      clk_q     <= (state_d == CLK_HI);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == COMMIT);
    end
  end

  assign controller_latch   = latch_q;
  assign controller_clk_out = clk_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign buttons_out        = buttons_q;

`ifdef CONTROLLER_POLLER_EDGE_EN
  chan_t edge_q;

  // New presses: set in a button that is down now and was up at the previous commit; held until the next commit.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      edge_q <= '0;
    end else if (state_d == COMMIT) begin
      edge_q <= buttons_d & ~buttons_q;
    end
  end

  assign pressed_edge = edge_q;
`else
  assign pressed_edge = '0;
`endif

endmodule

// File: tb/tb_controller_poller.sv
module tb_controller_poller;

`ifdef CONTROLLER_POLLER_EDGE_EN
  localparam bit EDGE_ON = 1'b1;
`else
  localparam bit EDGE_ON = 1'b0;
`endif

  logic clk_1 = 1'b0;
  always #5 clk_1 = ~clk_1;

  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  // Instance A: default parameters
  logic        poll_a;
  logic [1:0]  din_a;
  logic        latch_a, clko_a, busy_a, done_a;
  logic [15:0] btn_a, edge_a;

  // Instance B: 4 channels, 12 bits, half period of 3 cycles
  logic        poll_b;
  logic [3:0]  din_b;
  logic        latch_b, clko_b, busy_b, done_b;
  logic [47:0] btn_b, edge_b;

  controller_poller #(.NUM_CONTROLLERS(2), .NUM_BUTTONS(8), .HALF_PERIOD(1)) dut_a (
    .clk_1(clk_1), .rst_n(rst_n), .poll_req(poll_a), .controller_data_in_B(din_a),
    .controller_latch(latch_a), .controller_clk_out(clko_a), .buttons_out(btn_a),
    .pressed_edge(edge_a), .busy(busy_a), .done(done_a));

  controller_poller #(.NUM_CONTROLLERS(4), .NUM_BUTTONS(12), .HALF_PERIOD(3)) dut_b (
    .clk_1(clk_1), .rst_n(rst_n), .poll_req(poll_b), .controller_data_in_B(din_b),
    .controller_latch(latch_b), .controller_clk_out(clko_b), .buttons_out(btn_b),
    .pressed_edge(edge_b), .busy(busy_b), .done(done_b));

  // Controller models. The latch resets the bit index, and each rising edge of
  // the shift clock advances it. Index 0 is the button MSB, driven active-low.
  logic [7:0]  pat_a [2];
  logic [11:0] pat_b [4];
  int idx_a = 0;
  int idx_b = 0;

  always @(posedge latch_a or posedge clko_a or negedge rst_n) begin
    if (!rst_n || latch_a) idx_a <= 0;
    else                   idx_a <= idx_a + 1;
  end

  always @(posedge latch_b or posedge clko_b or negedge rst_n) begin
    if (!rst_n || latch_b) idx_b <= 0;
    else                   idx_b <= idx_b + 1;
  end

  always_comb begin
    for (int c = 0; c < 2; c++)
      din_a[c] = (idx_a < 8) ? ~pat_a[c][3'(7 - idx_a)] : 1'b1;
    for (int c = 0; c < 4; c++)
      din_b[c] = (idx_b < 12) ? ~pat_b[c][4'(11 - idx_b)] : 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Call this at a negedge. It raises poll_req for one edge, then samples
  // #1 after every edge until busy drops. The acceptance edge is k=0.
  // It can re-pulse poll_req at k=reissue_at.
  task automatic run_poll(input bit sel, input int reissue_at,
                          output int done_at, output int busy_cyc, output int latch_cyc,
                          output int clk_cyc, output int clk_pulses, output int done_cnt);
    logic dn, bs, lt, ck, ck_prev;
    done_at = -1; busy_cyc = 0; latch_cyc = 0; clk_cyc = 0; clk_pulses = 0; done_cnt = 0;
    ck_prev = 1'b0;
    bs = 1'b1;
    if (sel) poll_b = 1'b1; else poll_a = 1'b1;
    @(posedge clk_1); #1;
    poll_a = 1'b0; poll_b = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (k > 0) begin @(posedge clk_1); #1; end
      dn = sel ? done_b  : done_a;
      bs = sel ? busy_b  : busy_a;
      lt = sel ? latch_b : latch_a;
      ck = sel ? clko_b  : clko_a;
      if (dn) begin done_cnt++; if (done_at < 0) done_at = k; end
      if (bs) busy_cyc++;
      if (lt) latch_cyc++;
      if (ck) clk_cyc++;
      if (ck && !ck_prev) clk_pulses++;
      ck_prev = ck;
      if (k == reissue_at)     begin if (sel) poll_b = 1'b1; else poll_a = 1'b1; end
      if (k == reissue_at + 1) begin poll_a = 1'b0; poll_b = 1'b0; end
      if (!bs) break;
    end
    check("poll_terminates", 64'(bs), 64'd0);
  endtask

  int d_at, b_cyc, l_cyc, c_cyc, c_pul, d_cnt;
  int done_idx[$];
  int early_idle;
  int dc;

  initial begin
    rst_n = 1'b0; poll_a = 1'b0; poll_b = 1'b0;
    pat_a[0] = 8'b0111_1111; pat_a[1] = 8'b1111_1110;
    pat_b[0] = 12'hA5C; pat_b[1] = 12'h0F1; pat_b[2] = 12'hFFF; pat_b[3] = 12'h801;

    // Reset state
    repeat (3) @(posedge clk_1);
    #1;
    check("rst_latch", 64'(latch_a), 64'd0);
    check("rst_clk",   64'(clko_a),  64'd0);
    check("rst_busy",  64'(busy_a),  64'd0);
    check("rst_done",  64'(done_a),  64'd0);
    check("rst_btn",   64'(btn_a),   64'd0);
    check("rst_edge",  64'(edge_a),  64'd0);
    check("rst_b_btn", 64'(btn_b),   64'd0);
    @(negedge clk_1); rst_n = 1'b1;

    // Basic poll with default parameters
    @(negedge clk_1);
    run_poll(1'b0, -1, d_at, b_cyc, l_cyc, c_cyc, c_pul, d_cnt);
    $display("poll A basic: done_at=%0d busy=%0d btn=%h edge=%h", d_at, b_cyc, btn_a, edge_a);
    check("a_done_at",  64'(d_at),  64'd16);
    check("a_busy",     64'(b_cyc), 64'd17);
    check("a_latch",    64'(l_cyc), 64'd2);
    check("a_clk_puls", 64'(c_pul), 64'd7);
    check("a_done_cnt", 64'(d_cnt), 64'd1);
    check("a_btn",      64'(btn_a), 64'hFE7F);
    check("a_edge",     64'(edge_a), EDGE_ON ? 64'hFE7F : 64'd0);

    // Wide instance: 12 bits, half period 3, 4 channels
    @(negedge clk_1);
    run_poll(1'b1, -1, d_at, b_cyc, l_cyc, c_cyc, c_pul, d_cnt);
    $display("poll B wide: done_at=%0d busy=%0d btn=%h", d_at, b_cyc, btn_b);
    check("b_done_at",  64'(d_at),  64'd72);
    check("b_busy",     64'(b_cyc), 64'd73);
    check("b_latch",    64'(l_cyc), 64'd6);
    check("b_clk_high", 64'(c_cyc), 64'd33);
    check("b_clk_puls", 64'(c_pul), 64'd11);
    check("b_done_cnt", 64'(d_cnt), 64'd1);
    check("b_btn",      64'(btn_b), 64'h801FFF0F1A5C);
    check("b_edge",     64'(edge_b), EDGE_ON ? 64'h801FFF0F1A5C : 64'd0);

    // Second request 5 cycles into a poll is dropped
    @(negedge clk_1);
    run_poll(1'b0, 5, d_at, b_cyc, l_cyc, c_cyc, c_pul, d_cnt);
    $display("poll A reissue@5: done_cnt=%0d busy=%0d", d_cnt, b_cyc);
    check("re5_done_cnt", 64'(d_cnt), 64'd1);
    check("re5_busy",     64'(b_cyc), 64'd17);
    check("re5_btn",      64'(btn_a), 64'hFE7F);
    check("re5_edge",     64'(edge_a), 64'd0);

    // A request pulsed only during COMMIT is dropped
    @(negedge clk_1);
    run_poll(1'b0, 16, d_at, b_cyc, l_cyc, c_cyc, c_pul, d_cnt);
    $display("poll A pulse in COMMIT: done_cnt=%0d busy=%0d", d_cnt, b_cyc);
    check("cm_done_cnt", 64'(d_cnt), 64'd1);
    check("cm_busy",     64'(b_cyc), 64'd17);
    repeat (3) @(posedge clk_1);
    #1;
    check("cm_ignored",  64'(busy_a), 64'd0);

    // A held request runs back-to-back polls, one done every 17 cycles
    @(negedge clk_1);
    poll_a = 1'b1;
    early_idle = 0;
    for (int k = 0; k < 70; k++) begin
      @(posedge clk_1); #1;
      if (done_a) done_idx.push_back(k);
      if (!busy_a && k <= 50) early_idle++;
      if (k == 45) poll_a = 1'b0;
    end
    $display("held poll: dones=%0d idle_before_end=%0d", done_idx.size(), early_idle);
    check("held_count", 64'(done_idx.size()), 64'd3);
    check("held_d0",    64'(done_idx[0]), 64'd16);
    check("held_d1",    64'(done_idx[1]), 64'd33);
    check("held_d2",    64'(done_idx[2]), 64'd50);
    check("held_busy",  64'(early_idle), 64'd0);
    check("held_idle",  64'(busy_a), 64'd0);

    // Reset 9 cycles into a poll: outputs clear at once, no done
    @(negedge clk_1);
    poll_a = 1'b1;
    @(posedge clk_1); #1;
    poll_a = 1'b0;
    repeat (9) @(posedge clk_1);
    #1;
    rst_n = 1'b0;
    #1;
    $display("mid-poll reset: busy=%0d btn=%h", busy_a, btn_a);
    check("mr_busy",  64'(busy_a),  64'd0);
    check("mr_latch", 64'(latch_a), 64'd0);
    check("mr_clk",   64'(clko_a),  64'd0);
    check("mr_done",  64'(done_a),  64'd0);
    check("mr_btn",   64'(btn_a),   64'd0);
    check("mr_edge",  64'(edge_a),  64'd0);
    dc = 0;
    repeat (3) begin
      @(posedge clk_1); #1;
      if (done_a) dc++;
    end
    check("mr_no_done", 64'(dc), 64'd0);

    // Edge sequence. The first poll is accepted on the reset-release edge.
    pat_a[0] = 8'h01; pat_a[1] = 8'h00;
    @(negedge clk_1);
    rst_n = 1'b1;
    run_poll(1'b0, -1, d_at, b_cyc, l_cyc, c_cyc, c_pul, d_cnt);
    $display("edge poll 1: btn=%h edge=%h", btn_a, edge_a);
    check("e1_done_at", 64'(d_at),   64'd16);
    check("e1_busy",    64'(b_cyc),  64'd17);
    check("e1_btn",     64'(btn_a),  64'h0001);
    check("e1_edge",    64'(edge_a), EDGE_ON ? 64'h0001 : 64'd0);

    pat_a[0] = 8'h03;
    @(negedge clk_1);
    run_poll(1'b0, -1, d_at, b_cyc, l_cyc, c_cyc, c_pul, d_cnt);
    $display("edge poll 2: btn=%h edge=%h", btn_a, edge_a);
    check("e2_btn",  64'(btn_a),  64'h0003);
    check("e2_edge", 64'(edge_a), EDGE_ON ? 64'h0002 : 64'd0);

    @(negedge clk_1);
    run_poll(1'b0, -1, d_at, b_cyc, l_cyc, c_cyc, c_pul, d_cnt);
    $display("edge poll 3: btn=%h edge=%h", btn_a, edge_a);
    check("e3_btn",  64'(btn_a),  64'h0003);
    check("e3_edge", 64'(edge_a), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
